// File: rtl/sl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sl_pkg
//  Description : Shared SL definitions used by the transmitter, the receiver
//                and the APB bridge: FSM state encoding, line symbol types,
//                configuration-register field positions and bit-quantity
//                limits, plus the bit-quantity clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sl_pkg;

    // Transmitter FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_GAP    = 3'd4
    } sl_state_e;

    // Symbol requested from the symbol generator
    typedef enum logic [1:0] {
        SYM_IDLE = 2'd0,
        SYM_ZERO = 2'd1,
        SYM_ONE  = 2'd2,
        SYM_STOP = 2'd3
    } sl_sym_e;

    // Configuration register field positions
    localparam int PCE = 0;
    localparam int BQL = 1;
    localparam int BQH = 6;

    // Bit quantity limits
    localparam int BQ_MIN = 8;
    localparam int BQ_MAX = 32;

    // Clamp a requested bit quantity into BQ_MIN..BQ_MAX
    function automatic logic [5:0] bq_clamp(input logic [5:0] bq);
        if (bq < 6'(BQ_MIN)) begin
            return 6'(BQ_MIN);
        end
        if (bq > 6'(BQ_MAX)) begin
            return 6'(BQ_MAX);
        end
        return bq;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sl_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sl_transmitter_if
//  Description : Word/handshake/line bundle of the SL transmitter.
//                master : the word source (APB bridge side).
//                slave  : the transmitter.
//  Signals     : tx_data[31:0], cfg_bq[5:0], cfg_pce, tx_valid   (to slave)
//                tx_ready, tx_busy, tx_done, sl0_o, sl1_o          (from slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sl_transmitter_if;
    import sl_pkg::*;

    logic [31:0]      tx_data;
    logic [BQH-BQL:0] cfg_bq;
    logic             cfg_pce;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_busy;
    logic             tx_done;
    logic             sl0_o;
    logic             sl1_o;

    modport master (
        output tx_data, cfg_bq, cfg_pce, tx_valid,
        input  tx_ready, tx_busy, tx_done, sl0_o, sl1_o
    );

    modport slave (
        input  tx_data, cfg_bq, cfg_pce, tx_valid,
        output tx_ready, tx_busy, tx_done, sl0_o, sl1_o
    );

endinterface
`default_nettype wire

// File: rtl/sl_symbol_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sl_symbol_gen
//  Description : Symbol timing for the SL line. Owns the per-symbol cycle
//                counter and the symbol-end strobe, and drives the registered
//                SL0/SL1 lines low for the first PULSE_LEN cycles of each
//                ZERO/ONE/STOP symbol.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                i_run        - counter runs while high, held at 0 otherwise
//                i_sym        - symbol type for the current cycle
//                o_sym_end    - last cycle of the current symbol
//                o_sl0/o_sl1  - registered line drives, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module sl_symbol_gen
    import sl_pkg::*;
#(
    parameter int BIT_PERIOD = 16,
    parameter int PULSE_LEN  = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    i_run,
    input  wire sl_sym_e i_sym,
    output logic         o_sym_end,
    output logic         o_sl0,
    output logic         o_sl1
);

    localparam int                 c_cnt_w = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BIT_PERIOD - 1);
    localparam logic [c_cnt_w-1:0] c_pulse = c_cnt_w'(PULSE_LEN);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sl0;
    logic               r_sl1;
    logic               w_low;
    logic               w_drv0;
    logic               w_drv1;

    assign o_sym_end = i_run && (r_cnt == c_last);
    assign w_low     = i_run && (r_cnt < c_pulse);
    assign w_drv0    = w_low && ((i_sym == SYM_ZERO) || (i_sym == SYM_STOP));
    assign w_drv1    = w_low && ((i_sym == SYM_ONE)  || (i_sym == SYM_STOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || o_sym_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Line drives are registered, so the line trails the symbol state by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sl0 <= 1'b1;
            r_sl1 <= 1'b1;
        end else begin
            r_sl0 <= ~w_drv0;
            r_sl1 <= ~w_drv1;
        end
    end

    assign o_sl0 = r_sl0;
    assign o_sl1 = r_sl1;

endmodule
`default_nettype wire

// File: rtl/sl_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : sl_transmitter
//  Description : Serialises one word onto the two-wire SL line, LSB first:
//                a low pulse on SL0 is a 0, on SL1 a 1, both low is the stop
//                symbol. Sequence: DATA (N symbols) -> PARITY (optional) ->
//                STOP -> GAP (GAP_BITS idle symbols) -> IDLE.
//  Ports       : clk, rst_n   - SL core clock, async active-low reset
//                bus (slave)  - tx_data, cfg_bq, cfg_pce, tx_valid in;
//                               tx_ready, tx_busy, tx_done, sl0_o, sl1_o out
//  Config      : SL_TX_PARITY_EN - when defined, cfg_pce is honoured and an
//                odd-parity symbol follows the data; otherwise no parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int BIT_PERIOD = 16,
    parameter int PULSE_LEN  = 8,
    parameter int GAP_BITS   = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    sl_transmitter_if.slave bus
);

    localparam logic [5:0] c_gap_last = 6'(GAP_BITS - 1);

    sl_state_e   r_state;
    sl_state_e   w_next_state;
    sl_sym_e     w_sym;
    logic [31:0] r_shift;
    logic [5:0]  r_nbits;
    logic [5:0]  r_bit_cnt;
    logic        r_done;
    logic        w_accept;
    logic        w_run;
    logic        w_sym_end;
    logic        w_last_bit;
    logic        w_last_gap;
    logic [5:0]  w_nbits;
`ifdef SL_TX_PARITY_EN
    logic        r_par_en;
    logic        r_parity;
    logic [31:0] w_mask;
`endif

    assign w_accept   = (r_state == ST_IDLE) && bus.tx_valid;
    assign w_run      = (r_state != ST_IDLE);
    assign w_nbits    = bq_clamp(bus.cfg_bq);
    assign w_last_bit = (r_bit_cnt == (r_nbits - 6'd1));
    assign w_last_gap = (r_bit_cnt == c_gap_last);
`ifdef SL_TX_PARITY_EN
    // Keep only the N bits that will actually be sent (N is 8..32)
    assign w_mask     = 32'hFFFF_FFFF >> (6'd32 - w_nbits);
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.tx_valid) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_sym_end && w_last_bit) begin
`ifdef SL_TX_PARITY_EN
                    w_next_state = r_par_en ? ST_PARITY : ST_STOP;
`else
                    w_next_state = ST_STOP;
`endif
                end
            end
`ifdef SL_TX_PARITY_EN
            ST_PARITY: begin
                if (w_sym_end) begin
                    w_next_state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_sym_end) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_sym_end && w_last_gap) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_sym = SYM_IDLE;
        case (r_state)
            ST_DATA:   w_sym = r_shift[0] ? SYM_ONE : SYM_ZERO;
`ifdef SL_TX_PARITY_EN
            ST_PARITY: w_sym = r_parity ? SYM_ONE : SYM_ZERO;
`endif
            ST_STOP:   w_sym = SYM_STOP;
            default:   w_sym = SYM_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // The bit counter counts data symbols in DATA and idle symbols in GAP;
    // it is zero on entry to both states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_nbits   <= 6'(BQ_MIN);
            r_bit_cnt <= '0;
`ifdef SL_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_parity  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift   <= bus.tx_data;
            r_nbits   <= w_nbits;
            r_bit_cnt <= '0;
`ifdef SL_TX_PARITY_EN
            r_par_en  <= bus.cfg_pce;
            // Odd parity: ones in data plus parity bit is odd
            r_parity  <= ~^(bus.tx_data & w_mask);
`endif
        end else if (w_sym_end) begin
            if (r_state == ST_DATA) begin
                r_shift <= r_shift >> 1;
            end
            if (((r_state == ST_DATA) && !w_last_bit) ||
                ((r_state == ST_GAP)  && !w_last_gap)) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end else begin
                r_bit_cnt <= '0;
            end
        end
    end

    // Registered so it lines up with the last line cycle of the stop symbol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_STOP) && w_sym_end;
        end
    end

    sl_symbol_gen #(
        .BIT_PERIOD (BIT_PERIOD),
        .PULSE_LEN  (PULSE_LEN)
    ) u_symbol_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_run),
        .i_sym     (w_sym),
        .o_sym_end (w_sym_end),
        .o_sl0     (bus.sl0_o),
        .o_sl1     (bus.sl1_o)
    );

    assign bus.tx_ready = (r_state == ST_IDLE);
    assign bus.tx_busy  = (r_state != ST_IDLE);
    assign bus.tx_done  = r_done;

endmodule
`default_nettype wire
